// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - BCD stopwatch SS.hh with start/stop/clear and 4-digit 7-segment scan; optional lap hold via STOPWATCH_LAP_EN
module stopwatch_core #(
    parameter logic WRAP_ON_MAX    = 1'b1,
    parameter logic SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_10ms,
    input  logic       refresh_clk,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       running,
    output logic       overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    // Polarity flip applied to every display output when the board is active-high.
    localparam logic INV = !SEG_ACTIVE_LOW;

    state_t     state;
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] n0, n1, n2, n3;
    logic       at_max;
    logic       count_en;

    logic [3:0] s0, s1, s2, s3;
    logic [1:0] idx;
    logic       refresh_prev;
    logic       refresh_rise;
    logic [3:0] disp_digit;

    // Segment pattern {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign count_en = (state == ST_RUN) && tick_10ms;
    assign at_max   = (d0 == 4'd9) && (d1 == 4'd9) && (d2 == 4'd9) && (d3 == 4'd9);

    // BCD increment with the full carry chain resolved combinationally.
    always_comb begin
        n0 = (d0 == 4'd9) ? 4'd0 : d0 + 4'd1;
        n1 = d1;
        n2 = d2;
        n3 = d3;
        if (d0 == 4'd9) begin
            n1 = (d1 == 4'd9) ? 4'd0 : d1 + 4'd1;
            if (d1 == 4'd9) begin
                n2 = (d2 == 4'd9) ? 4'd0 : d2 + 4'd1;
                if (d2 == 4'd9) begin
                    n3 = (d3 == 4'd9) ? 4'd0 : d3 + 4'd1;
                end
            end
        end
    end

    // Control FSM plus time digits; counting looks at the state before this edge's transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            running  <= 1'b0;
            overflow <= 1'b0;
            d0       <= 4'd0;
            d1       <= 4'd0;
            d2       <= 4'd0;
            d3       <= 4'd0;
        end else begin
            overflow <= 1'b0;
            if (clear) begin
                state   <= ST_IDLE;
                running <= 1'b0;
                d0      <= 4'd0;
                d1      <= 4'd0;
                d2      <= 4'd0;
                d3      <= 4'd0;
            end else begin
                if (count_en && at_max && !WRAP_ON_MAX) begin
                    state   <= ST_STOP;
                    running <= 1'b0;
                end else if (start_stop) begin
                    case (state)
                        ST_RUN: begin
                            state   <= ST_STOP;
                            running <= 1'b0;
                        end
                        default: begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    endcase
                end
                if (count_en) begin
                    if (at_max) begin
                        if (WRAP_ON_MAX) begin
                            d0       <= 4'd0;
                            d1       <= 4'd0;
                            d2       <= 4'd0;
                            d3       <= 4'd0;
                            overflow <= 1'b1;
                        end
                    end else begin
                        d0 <= n0;
                        d1 <= n1;
                        d2 <= n2;
                        d3 <= n3;
                    end
                end
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic       lap_active;
    logic [3:0] l0, l1, l2, l3;

    // Lap hold: first lap in RUN freezes a snapshot; next lap, start_stop or clear releases it.
    always_ff @(posedge clk) begin
        if (reset) begin
            lap_active <= 1'b0;
            l0         <= 4'd0;
            l1         <= 4'd0;
            l2         <= 4'd0;
            l3         <= 4'd0;
        end else if (clear || start_stop) begin
            lap_active <= 1'b0;
        end else if (lap) begin
            if (lap_active) begin
                lap_active <= 1'b0;
            end else if (state == ST_RUN) begin
                lap_active <= 1'b1;
                l0         <= d0;
                l1         <= d1;
                l2         <= d2;
                l3         <= d3;
            end
        end
    end

    assign s0 = lap_active ? l0 : d0;
    assign s1 = lap_active ? l1 : d1;
    assign s2 = lap_active ? l2 : d2;
    assign s3 = lap_active ? l3 : d3;
`else
    logic lap_unused;
    assign lap_unused = lap;
    assign s0 = d0;
    assign s1 = d1;
    assign s2 = d2;
    assign s3 = d3;
`endif

    assign refresh_rise = refresh_clk & ~refresh_prev;

    // Scan index advances once per refresh_clk rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_prev <= 1'b0;
            idx          <= 2'd0;
        end else begin
            refresh_prev <= refresh_clk;
            if (refresh_rise) begin
                idx <= idx + 2'd1;
            end
        end
    end

    // Pick the digit currently being scanned.
    always_comb begin
        case (idx)
            2'd0:    disp_digit = s0;
            2'd1:    disp_digit = s1;
            2'd2:    disp_digit = s2;
            default: disp_digit = s3;
        endcase
    end

    // Registered display drive; the decimal point sits after the seconds units digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 4'b1110 ^ {4{INV}};
            seg <= 7'b1000000 ^ {7{INV}};
            dp  <= 1'b1 ^ INV;
        end else begin
            an  <= ~(4'b0001 << idx) ^ {4{INV}};
            seg <= seg_decode(disp_digit) ^ {7{INV}};
            dp  <= (idx != 2'd2) ^ INV;
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - directed table-driven bench for stopwatch_core (wrap and hold instances)
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_10ms = 1'b0;
    logic       refresh_clk = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;

    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [3:0] an_a, an_b;
    logic       running_a, running_b;
    logic       overflow_a, overflow_b;

    int n_pass = 0;
    int n_total = 0;
    logic ov_seen;

    always #5 clk = ~clk;

    stopwatch_core #(.WRAP_ON_MAX(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .reset(reset), .tick_10ms(tick_10ms), .refresh_clk(refresh_clk),
        .start_stop(start_stop), .clear(clear), .lap(lap),
        .seg(seg_a), .dp(dp_a), .an(an_a), .running(running_a), .overflow(overflow_a)
    );

    stopwatch_core #(.WRAP_ON_MAX(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .reset(reset), .tick_10ms(tick_10ms), .refresh_clk(refresh_clk),
        .start_stop(start_stop), .clear(clear), .lap(lap),
        .seg(seg_b), .dp(dp_b), .an(an_b), .running(running_b), .overflow(overflow_b)
    );

    typedef struct {
        logic ss;
        logic clr;
        logic tk;
        logic exp_run;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic ss, input logic clr, input logic tk, input logic lp);
        start_stop = ss; clear = clr; tick_10ms = tk; lap = lp;
        step();
        start_stop = 1'b0; clear = 1'b0; tick_10ms = 1'b0; lap = 1'b0;
    endtask

    task automatic tick_n(input int n);
        ov_seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick_10ms = 1'b1;
            step();
            ov_seen = ov_seen | overflow_a;
        end
        tick_10ms = 1'b0;
    endtask

    // Four refresh rises; at each, check the lit position shows the expected digit.
    task automatic check_disp(input string nm, input bit sel_b,
                              input logic [3:0] e3, input logic [3:0] e2,
                              input logic [3:0] e1, input logic [3:0] e0);
        logic [3:0] exp_d [4];
        logic [3:0] an_s;
        logic [6:0] seg_s;
        logic       dp_s;
        int         pos;
        exp_d[0] = e0; exp_d[1] = e1; exp_d[2] = e2; exp_d[3] = e3;
        for (int k = 0; k < 4; k++) begin
            refresh_clk = 1'b1;
            step();
            step();
            an_s  = sel_b ? an_b : an_a;
            seg_s = sel_b ? seg_b : seg_a;
            dp_s  = sel_b ? dp_b : dp_a;
            refresh_clk = 1'b0;
            step();
            pos = 0;
            for (int j = 0; j < 4; j++) if (!an_s[j]) pos = j;
            chk({nm, "_an_onehot"}, $countones(~an_s), 1);
            chk({nm, "_seg"}, seg_s, enc(exp_d[pos]));
            chk({nm, "_dp"}, dp_s, (pos == 2) ? 1'b0 : 1'b1);
        end
    endtask

    initial begin
        vecs[0]  = '{ss: 0, clr: 0, tk: 1, exp_run: 0};
        vecs[1]  = '{ss: 1, clr: 0, tk: 0, exp_run: 1};
        vecs[2]  = '{ss: 0, clr: 0, tk: 1, exp_run: 1};
        vecs[3]  = '{ss: 1, clr: 0, tk: 1, exp_run: 0};
        vecs[4]  = '{ss: 0, clr: 0, tk: 1, exp_run: 0};
        vecs[5]  = '{ss: 1, clr: 0, tk: 0, exp_run: 1};
        vecs[6]  = '{ss: 1, clr: 1, tk: 0, exp_run: 0};
        vecs[7]  = '{ss: 1, clr: 0, tk: 0, exp_run: 1};
        vecs[8]  = '{ss: 0, clr: 1, tk: 0, exp_run: 0};
        vecs[9]  = '{ss: 1, clr: 0, tk: 0, exp_run: 1};
        vecs[10] = '{ss: 1, clr: 0, tk: 0, exp_run: 0};
        vecs[11] = '{ss: 1, clr: 0, tk: 0, exp_run: 1};
        vecs[12] = '{ss: 0, clr: 1, tk: 0, exp_run: 0};

        // Reset state
        step();
        step();
        reset = 1'b0;
        chk("rst_an", an_a, 4'b1110);
        chk("rst_seg", seg_a, 7'b1000000);
        chk("rst_dp", dp_a, 1'b1);
        chk("rst_running", running_a, 1'b0);
        chk("rst_overflow", overflow_a, 1'b0);

        // Control table: one cycle per vector
        for (int i = 0; i < 13; i++) begin
            pulse(vecs[i].ss, vecs[i].clr, vecs[i].tk, 1'b0);
            chk($sformatf("vec%0d_running", i), running_a, vecs[i].exp_run);
            chk($sformatf("vec%0d_overflow", i), overflow_a, 1'b0);
        end
        check_disp("after_table", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);

        // 150 ticks in RUN
        pulse(1, 0, 0, 0);
        tick_n(150);
        chk("t1_running", running_a, 1'b1);
        chk("t1_no_overflow", ov_seen, 1'b0);
        check_disp("t1_0150", 1'b0, 4'd0, 4'd1, 4'd5, 4'd0);

        // Stop coinciding with a tick: tick counted, then frozen, then resumed
        pulse(1, 0, 1, 0);
        chk("t2_stopped", running_a, 1'b0);
        tick_n(10);
        check_disp("t2_0151", 1'b0, 4'd0, 4'd1, 4'd5, 4'd1);
        pulse(1, 0, 0, 0);
        chk("t2_resumed", running_a, 1'b1);
        tick_n(1);
        check_disp("t2_0152", 1'b0, 4'd0, 4'd1, 4'd5, 4'd2);

        // Clear beats start_stop while running
        pulse(1, 1, 0, 0);
        chk("t4_running", running_a, 1'b0);
        check_disp("t4_0000", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);

        // Preload to 99.98, then across the maximum
        pulse(1, 0, 0, 0);
        tick_n(9998);
        check_disp("t3_9998", 1'b0, 4'd9, 4'd9, 4'd9, 4'd8);
        tick_10ms = 1'b1;
        step();
        chk("t3_no_ov_at_9999", overflow_a, 1'b0);
        step();
        tick_10ms = 1'b0;
        chk("t3_wrap_overflow", overflow_a, 1'b1);
        chk("t3_wrap_running", running_a, 1'b1);
        chk("t3_hold_running", running_b, 1'b0);
        chk("t3_hold_overflow", overflow_b, 1'b0);
        step();
        chk("t3_overflow_1clk", overflow_a, 1'b0);
        tick_n(3);
        check_disp("t3_hold_9999", 1'b1, 4'd9, 4'd9, 4'd9, 4'd9);
        check_disp("t3_wrap_0003", 1'b0, 4'd0, 4'd0, 4'd0, 4'd3);

        // 12.34 scan order and output latency
        pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        tick_n(1234);
        pulse(1, 0, 0, 0);
        chk("t5_stopped", running_a, 1'b0);
        refresh_clk = 1'b1;
        step();
        chk("t5_r1_lag", an_a, 4'b1110);
        step();
        chk("t5_r1_an", an_a, 4'b1101);
        chk("t5_r1_seg", seg_a, enc(4'd3));
        chk("t5_r1_dp", dp_a, 1'b1);
        step();
        step();
        chk("t5_r1_held_high", an_a, 4'b1101);
        refresh_clk = 1'b0;
        step();
        refresh_clk = 1'b1;
        step();
        step();
        chk("t5_r2_an", an_a, 4'b1011);
        chk("t5_r2_seg", seg_a, enc(4'd2));
        chk("t5_r2_dp", dp_a, 1'b0);
        refresh_clk = 1'b0;
        step();
        refresh_clk = 1'b1;
        step();
        step();
        chk("t5_r3_an", an_a, 4'b0111);
        chk("t5_r3_seg", seg_a, enc(4'd1));
        chk("t5_r3_dp", dp_a, 1'b1);
        refresh_clk = 1'b0;
        step();
        refresh_clk = 1'b1;
        step();
        step();
        chk("t5_r4_an", an_a, 4'b1110);
        chk("t5_r4_seg", seg_a, enc(4'd4));
        chk("t5_r4_dp", dp_a, 1'b1);
        refresh_clk = 1'b0;
        step();

`ifdef STOPWATCH_LAP_EN
        // Lap snapshot holds the display while counting continues
        pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        tick_n(321);
        pulse(0, 0, 0, 1);
        tick_n(50);
        chk("t6_running", running_a, 1'b1);
        check_disp("t6_lap_0321", 1'b0, 4'd0, 4'd3, 4'd2, 4'd1);
        pulse(0, 0, 0, 1);
        check_disp("t6_live_0371", 1'b0, 4'd0, 4'd3, 4'd7, 4'd1);
`else
        // Lap has no effect without the lap feature
        pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        tick_n(5);
        pulse(0, 0, 0, 1);
        tick_n(3);
        chk("lap_ignored_running", running_a, 1'b1);
        check_disp("lap_ignored_0008", 1'b0, 4'd0, 4'd0, 4'd0, 4'd8);
`endif

        // Reset mid-count
        tick_n(7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_running", running_a, 1'b0);
        chk("midrst_an", an_a, 4'b1110);
        chk("midrst_seg", seg_a, 7'b1000000);
        chk("midrst_dp", dp_a, 1'b1);
        tick_n(4);
        chk("midrst_idle", running_a, 1'b0);
        check_disp("midrst_0000", 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
